// File: rtl/cbf_fir_pkg.sv
// rtl/cbf_fir_pkg.sv - shared types and helpers for the serial decimating FIR
//
// Contents:
//   coef_t      signed coefficient type at the default width
//   state_e     frame FSM states
//   acc_width   width of the signed accumulator for a given configuration
//   sat_offset  clamps to the signed output range and converts to offset binary
package cbf_fir_pkg;

    localparam int CBF_COEF_W = 24;

    typedef logic signed [CBF_COEF_W-1:0] coef_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } state_e;

    // One sign bit plus headroom for TAPS*M full-scale terms
    function automatic int acc_width(int coef_w, int taps, int m);
        return coef_w + $clog2(taps * m) + 1;
    endfunction

    // Low out_w bits of the return value are the offset-binary sample.
    // Offset binary equals the two's complement value with its MSB inverted.
    function automatic logic [63:0] sat_offset(logic signed [63:0] v, int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] s;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi) begin
            s = hi;
        end else if (v < lo) begin
            s = lo;
        end else begin
            s = v;
        end
        return $unsigned(s) ^ (64'd1 << (out_w - 1));
    endfunction

endpackage

// File: rtl/cbf_lane_sum.sv
// rtl/cbf_lane_sum.sv - combinational signed sum of LANES*M +/-coefficient terms
//
// Ports:
//   bits_i   control bits for one beat, bit l*M+m = tap l, channel m
//   coefs_i  matching coefficients, element i at [i*COEF_W +: COEF_W]
//   sum_o    sum over i of (bits_i[i] ? +coef : -coef)
module cbf_lane_sum
    import cbf_fir_pkg::*;
#(
    parameter int M      = 4,
    parameter int LANES  = 8,
    parameter int COEF_W = 24,
    parameter int ACC_W  = 33
) (
    input  logic [LANES*M-1:0]        bits_i,
    input  logic [LANES*M*COEF_W-1:0] coefs_i,
    output logic signed [ACC_W-1:0]   sum_o
);

    logic signed [COEF_W-1:0] c;

    always_comb begin
        sum_o = '0;
        c     = '0;
        for (int i = 0; i < LANES * M; i++) begin
            c = coefs_i[i*COEF_W +: COEF_W];
            if (bits_i[i]) begin
                sum_o = sum_o + ACC_W'(c);
            end else begin
                sum_o = sum_o - ACC_W'(c);
            end
        end
    end

endmodule

// File: rtl/cbf_fir_serial.sv
// rtl/cbf_fir_serial.sv - runtime-configurable serial decimating FIR, top level
//
// Optional feature: define CBF_ROUND_EN for round-half-up, otherwise floor.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in                M-bit control vector, one per clock
//   dsr               requested decimation ratio (clamped, see cfg_err)
//   coef_we/addr/data coefficient write port, index k*M+m
//   out, out_valid    offset-binary sample with valid/ready handshake
//   out_ready         consumer accepts
//   busy              frame computation in progress
//   overrun, ovr_clr  sticky dropped-result flag and its clear
//   cfg_err           last latched dsr was out of range
module cbf_fir_serial
    import cbf_fir_pkg::*;
#(
    parameter int M         = 4,
    parameter int TAPS      = 64,
    parameter int LANES     = 8,
    parameter int DSR_MAX   = 32,
    parameter int COEF_W    = 24,
    parameter int COEF_FRAC = 22,
    parameter int OUT_WIDTH = 14
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [M-1:0]                  in,
    input  logic [$clog2(DSR_MAX+1)-1:0]  dsr,
    input  logic                          coef_we,
    input  logic [$clog2(TAPS*M)-1:0]     coef_addr,
    input  logic signed [COEF_W-1:0]      coef_data,
    output logic [OUT_WIDTH-1:0]          out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          overrun,
    input  logic                          ovr_clr,
    output logic                          cfg_err
);

    localparam int BEATS   = TAPS / LANES;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DSR_W   = $clog2(DSR_MAX + 1);
    localparam int FILL_W  = $clog2(TAPS + 1);
    localparam int ACC_W   = acc_width(COEF_W, TAPS, M);
    localparam int SHIFT   = COEF_FRAC - OUT_WIDTH + 1;
    // Smallest ratio that lets FIN finish before the next frame cycle
    localparam int DSR_MIN = BEATS + 2;

    // hist_q holds ages 1..TAPS-1; age 0 is the live input
    logic [TAPS-2:0][M-1:0]        hist_q;
    logic [TAPS-1:0][M-1:0]        hist_d;
    logic [TAPS-1:0][M-1:0]        frame_q, frame_d;
    logic [TAPS*M-1:0][COEF_W-1:0] coef_q;
    logic [FILL_W-1:0]             fill_q, fill_d;
    logic [DSR_W-1:0]              phase_q, phase_d;
    logic [DSR_W-1:0]              dsr_eff_q, dsr_eff_d;
    logic                          cfg_err_q, cfg_err_d;
    logic                          full_q, full_d;
    state_e                        state_q, state_d;
    logic [BEAT_W-1:0]             beat_q, beat_d;
    logic signed [ACC_W-1:0]       acc_q, acc_d;
    logic [OUT_WIDTH-1:0]          out_q, out_d;
    logic                          out_valid_q, out_valid_d;
    logic                          overrun_q, overrun_d;

    logic [DSR_W-1:0]              dsr_clamp;
    logic                          dsr_bad;
    logic                          frame_cyc;
    logic [LANES*M-1:0]            lane_bits;
    logic [LANES*M*COEF_W-1:0]     lane_coefs;
    logic signed [ACC_W-1:0]       lane_sum;
    logic signed [63:0]            acc_ext;
    logic [OUT_WIDTH-1:0]          result;

    always_comb begin
        dsr_clamp = dsr;
        dsr_bad   = 1'b0;
        if (dsr < DSR_W'(DSR_MIN)) begin
            dsr_clamp = DSR_W'(DSR_MIN);
            dsr_bad   = 1'b1;
        end else if (dsr > DSR_W'(DSR_MAX)) begin
            dsr_clamp = DSR_W'(DSR_MAX);
            dsr_bad   = 1'b1;
        end
    end

    assign frame_cyc = (phase_q == dsr_eff_q - DSR_W'(1));

    assign lane_bits  = frame_q[int'(beat_q)*LANES +: LANES];
    assign lane_coefs = coef_q[int'(beat_q)*LANES*M +: LANES*M];

    cbf_lane_sum #(
        .M      (M),
        .LANES  (LANES),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_lane_sum (
        .bits_i  (lane_bits),
        .coefs_i (lane_coefs),
        .sum_o   (lane_sum)
    );

    always_comb begin
        acc_ext = 64'(acc_q);
`ifdef CBF_ROUND_EN
        acc_ext = acc_ext + (64'sd1 <<< (SHIFT - 1));
`endif
        result = OUT_WIDTH'(sat_offset(acc_ext >>> SHIFT, OUT_WIDTH));
    end

    always_comb begin
        hist_d    = {hist_q, in};
        fill_d    = (fill_q == FILL_W'(TAPS)) ? fill_q : fill_q + FILL_W'(1);
        phase_d   = phase_q + DSR_W'(1);
        dsr_eff_d = dsr_eff_q;
        cfg_err_d = cfg_err_q;
        frame_d   = frame_q;
        full_d    = full_q;
        if (frame_cyc) begin
            phase_d   = '0;
            dsr_eff_d = dsr_clamp;
            cfg_err_d = dsr_bad;
            frame_d   = hist_d;
            full_d    = (fill_d == FILL_W'(TAPS));
        end

        state_d     = state_q;
        beat_d      = beat_q;
        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = out_valid_q && !out_ready;
        overrun_d   = overrun_q && !ovr_clr;
        unique case (state_q)
            ST_IDLE: begin
                if (frame_cyc) begin
                    acc_d   = '0;
                    beat_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d  = acc_q + lane_sum;
                beat_d = beat_q + BEAT_W'(1);
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                if (full_q) begin
                    if (out_valid_q && !out_ready) begin
                        overrun_d = 1'b1;
                    end else begin
                        out_d       = result;
                        out_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q      <= '0;
            frame_q     <= '0;
            coef_q      <= '0;
            fill_q      <= '0;
            phase_q     <= '0;
            dsr_eff_q   <= dsr_clamp;
            cfg_err_q   <= 1'b0;
            full_q      <= 1'b0;
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            hist_q      <= hist_d[TAPS-2:0];
            frame_q     <= frame_d;
            fill_q      <= fill_d;
            phase_q     <= phase_d;
            dsr_eff_q   <= dsr_eff_d;
            cfg_err_q   <= cfg_err_d;
            full_q      <= full_d;
            state_q     <= state_d;
            beat_q      <= beat_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            if (coef_we) begin
                coef_q[coef_addr] <= coef_data;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign overrun   = overrun_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_cbf_fir_serial.sv
// tb/tb_cbf_fir_serial.sv - scoreboard testbench for cbf_fir_serial
`timescale 1ns/1ps
module tb_cbf_fir_serial;
    import cbf_fir_pkg::*;

    logic        clk = 1'b0;
    logic        rst, coef_we, out_ready, ovr_clr;
    logic        out_valid, busy, overrun, cfg_err;
    logic [3:0]  in_v;
    logic [5:0]  dsr;
    logic [7:0]  coef_addr;
    coef_t       coef_data;
    logic [13:0] out_v;

    always #5 clk = ~clk;

    cbf_fir_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_v),
        .dsr       (dsr),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out       (out_v),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr),
        .cfg_err   (cfg_err)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int xfer     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: M=4, TAPS=64, shift 9, 14-bit output
    logic [3:0]  m_hist [64];
    coef_t       m_coef [256];
    int          m_fill, m_phase, m_dsr_eff, cyc;
    logic [13:0] exp_q [$];

    function automatic int clamp_dsr(int d);
        if (d < 10) return 10;
        if (d > 32) return 32;
        return d;
    endfunction

    function automatic logic [13:0] expect_out();
        longint acc = 0;
        longint r;
        for (int k = 0; k < 64; k++) begin
            for (int m = 0; m < 4; m++) begin
                if (m_hist[k][m]) acc += longint'(m_coef[k*4+m]);
                else              acc -= longint'(m_coef[k*4+m]);
            end
        end
`ifdef CBF_ROUND_EN
        acc += 256;
`endif
        r = acc >>> 9;
        if (r > 8191)  r = 8191;
        if (r < -8192) r = -8192;
        return 14'(r + 8192);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 64; k++) m_hist[k] = '0;
            for (int i = 0; i < 256; i++) m_coef[i] = '0;
            m_fill    = 0;
            m_phase   = 0;
            m_dsr_eff = clamp_dsr(int'(dsr));
            cyc       = 0;
            exp_q.delete();
        end else begin
            for (int k = 63; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = in_v;
            if (m_fill < 64) m_fill++;
            if (m_phase == m_dsr_eff - 1) begin
                if (m_fill >= 64) exp_q.push_back(expect_out());
                m_phase   = 0;
                m_dsr_eff = clamp_dsr(int'(dsr));
            end else begin
                m_phase++;
            end
            if (coef_we) m_coef[coef_addr] = coef_data;
            cyc++;
        end
    end

    // Every accepted output is popped against the model
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(exp_q.size()), 32'd1);
            end else begin
                check("sample", 32'(out_v), 32'(exp_q[0]));
                void'(exp_q.pop_front());
                xfer++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) in_v = 4'($urandom);
            tick();
        end
    endtask

    task automatic do_reset(input int d);
        rst = 1'b1; dsr = 6'(d); coef_we = 1'b0; ovr_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic write_coef(input int addr, input int val);
        coef_we = 1'b1; coef_addr = 8'(addr); coef_data = coef_t'(val);
        tick();
        coef_we = 1'b0;
    endtask

    task automatic wait_valid(input bit rnd, output int c);
        int n = 0;
        while (out_valid !== 1'b1 && n < 300) begin
            if (rnd) in_v = 4'($urandom);
            tick();
            n++;
        end
        check("wait_valid", 32'(out_valid), 32'd1);
        c = cyc;
    endtask

    // Skips two outputs so a new dsr has taken effect, then measures spacing
    task automatic measure_period(output int p);
        int a, b;
        wait_valid(0, a); tick();
        wait_valid(0, a); tick();
        wait_valid(0, a); tick();
        wait_valid(0, b);
        p = b - a;
    endtask

    initial begin
        int c, c2, p, n;
        in_v = '0; out_ready = 1'b1; coef_addr = '0; coef_data = '0;

        // Zero coefficients: reset state, warm-up latency, mid-scale output.
        // Frame cycles 9,19,..; 69 is the first with >=64 samples, so
        // FIN at 78 and valid first seen once 79 cycles have elapsed.
        do_reset(10);
        check("rst_out", 32'(out_v), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        wait_valid(1, c);
        check("first_valid_cycle", 32'(c), 32'd79);
        run(60, 1);
        check("zero_coef_out", 32'(out_v), 32'h2000);
        check("zero_coef_xfers", 32'(xfer >= 5), 32'd1);

        // Single coefficient of 0.25
        do_reset(10);
        in_v = 4'hF;
        write_coef(0, 1 << 20);
        run(100, 0);
        check("quarter_pos", 32'(out_v), 32'h2800);
        in_v = 4'h0;
        run(80, 0);
        check("quarter_neg", 32'(out_v), 32'h1800);

        // Eight coefficients of 0.25 saturate both ways
        do_reset(10);
        in_v = 4'hF;
        for (int i = 0; i < 8; i++) write_coef(i, 1 << 20);
        run(100, 0);
        check("sat_pos", 32'(out_v), 32'h3FFF);
        in_v = 4'h0;
        run(80, 0);
        check("sat_neg", 32'(out_v), 32'h0000);

        // Half an output LSB
        do_reset(10);
        in_v = 4'hF;
        write_coef(0, 1 << 8);
        run(100, 0);
`ifdef CBF_ROUND_EN
        check("half_lsb", 32'(out_v), 32'h2001);
`else
        check("half_lsb", 32'(out_v), 32'h2000);
`endif

        // Backpressure: held result, dropped second result, clear, drain
        do_reset(10);
        out_ready = 1'b0;
        in_v = 4'hF;
        write_coef(0, 1 << 20);
        wait_valid(0, c);
        check("bp_first_cycle", 32'(c), 32'd79);
        run(12, 0);
        check("bp_overrun", 32'(overrun), 32'd1);
        check("bp_valid_held", 32'(out_valid), 32'd1);
        check("bp_out_held", 32'(out_v), 32'h2800);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("bp_ovr_clr", 32'(overrun), 32'd0);
        check("bp_queue", 32'(exp_q.size()), 32'd3);
        if (exp_q.size() > 1) exp_q.delete(1);
        out_ready = 1'b1;
        tick();
        check("bp_valid_cleared", 32'(out_valid), 32'd0);
        run(30, 0);

        // Decimation clamping and output period
        do_reset(3);
        in_v = 4'hF;
        write_coef(0, 1 << 20);
        wait_valid(0, c);
        check("dsr3_first_cycle", 32'(c), 32'd79);
        check("dsr3_cfg_err", 32'(cfg_err), 32'd1);
        tick();
        wait_valid(0, c2);
        check("dsr3_period", 32'(c2 - c), 32'd10);
        dsr = 6'd12;
        measure_period(p);
        check("dsr12_period", 32'(p), 32'd12);
        check("dsr12_cfg_err", 32'(cfg_err), 32'd0);
        dsr = 6'd40;
        measure_period(p);
        check("dsr40_period", 32'(p), 32'd32);
        check("dsr40_cfg_err", 32'(cfg_err), 32'd1);

        // Reset in the middle of RUN
        n = 0;
        while (busy !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        tick(); tick();
        check("mid_run_busy", 32'(busy), 32'd1);
        rst = 1'b1; dsr = 6'd10;
        tick();
        rst = 1'b0;
        check("mid_rst_out", 32'(out_v), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cfg_err", 32'(cfg_err), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
        wait_valid(0, c);
        check("mid_rst_first_cycle", 32'(c), 32'd79);
        check("mid_rst_coef_cleared", 32'(out_v), 32'h2000);
        run(20, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
